// File: rtl/sr_pipe_ctrl.sv
// Hazard/sequencing controller for the sr_cpu fetch-decode-execute-writeback pipe.
// Latency: stall, forward and first flush cycle are combinational; later flush cycles are registered.
// Backpressure: holds PC and fetch/decode on a RAW hazard; a taken branch flushes and overrides any stall.
//
// Optional feature macro: SR_PIPE_FWD_EN
//   defined   -> EX/WB operand forwarding, RAW hazards never stall
//   undefined -> forwarding selects tied to 00, every RAW match stalls with a bubble
//
// Ports:
//   clk, rst                      core clock, asynchronous active-high reset
//   id_rs1_i/id_rs2_i             decode source register indices
//   id_useRs1_i/id_useRs2_i       decode instruction really reads rs1/rs2
//   ex_rd_i, ex_regWrite_i        execute-stage destination and write enable
//   ex_branchTaken_i              branch in execute resolved taken
//   wb_rd_i, wb_regWrite_i        writeback-stage destination and write enable
//   pcStall_o, fdStall_o          hold PC / fetch-decode register
//   fdFlush_o, deFlush_o          bubble fetch-decode / decode-execute register
//   fwdA_o, fwdB_o                operand select: 00 regfile, 01 EX result, 10 WB data
//   stallCnt_o, flushCnt_o        saturating performance counters

module sr_pipe_ctrl #(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1_i,
  input  logic [4:0]       id_rs2_i,
  input  logic             id_useRs1_i,
  input  logic             id_useRs2_i,
  input  logic [4:0]       ex_rd_i,
  input  logic             ex_regWrite_i,
  input  logic             ex_branchTaken_i,
  input  logic [4:0]       wb_rd_i,
  input  logic             wb_regWrite_i,
  output logic             pcStall_o,
  output logic             fdStall_o,
  output logic             fdFlush_o,
  output logic             deFlush_o,
  output logic [1:0]       fwdA_o,
  output logic [1:0]       fwdB_o,
  output logic [CNT_W-1:0] stallCnt_o,
  output logic [CNT_W-1:0] flushCnt_o
);

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  localparam logic [2:0] LP_CNT_INIT = 3'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] LP_CNT_ONE = CNT_W'(1);

  state_t           r_state;
  logic [2:0]       r_cnt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  logic       w_match_ex_rs1;
  logic       w_match_ex_rs2;
  logic       w_match_wb_rs1;
  logic       w_match_wb_rs2;
  logic       w_branch_accept;
  logic       w_flush;
  logic       w_stall;
  logic [1:0] w_fwd_a;
  logic [1:0] w_fwd_b;

  // Register x0 is hardwired to zero, so a write to it is never a real producer.
  assign w_match_ex_rs1 = id_useRs1_i & ex_regWrite_i & (ex_rd_i == id_rs1_i) & (id_rs1_i != 5'd0);
  assign w_match_ex_rs2 = id_useRs2_i & ex_regWrite_i & (ex_rd_i == id_rs2_i) & (id_rs2_i != 5'd0);
  assign w_match_wb_rs1 = id_useRs1_i & wb_regWrite_i & (wb_rd_i == id_rs1_i) & (id_rs1_i != 5'd0);
  assign w_match_wb_rs2 = id_useRs2_i & wb_regWrite_i & (wb_rd_i == id_rs2_i) & (id_rs2_i != 5'd0);

  // Branches are only accepted in RUN; during FLUSH execute holds bubbles.
  assign w_branch_accept = ~rst & (r_state == ST_RUN) & ex_branchTaken_i;
  assign w_flush         = w_branch_accept | (~rst & (r_state == ST_FLUSH));

`ifdef SR_PIPE_FWD_EN
  // Execute holds the younger writer, so it wins over writeback.
  always_comb begin
    w_fwd_a = 2'b00;
    w_fwd_b = 2'b00;
    if (!rst) begin
      if (w_match_ex_rs1)      w_fwd_a = 2'b01;
      else if (w_match_wb_rs1) w_fwd_a = 2'b10;
      if (w_match_ex_rs2)      w_fwd_b = 2'b01;
      else if (w_match_wb_rs2) w_fwd_b = 2'b10;
    end
  end
  assign w_stall = 1'b0;
`else
  logic w_raw;
  assign w_fwd_a = 2'b00;
  assign w_fwd_b = 2'b00;
  assign w_raw   = w_match_ex_rs1 | w_match_ex_rs2 | w_match_wb_rs1 | w_match_wb_rs2;
  // A flush discards the stalled decode instruction, so the PC must be free to load the target.
  assign w_stall = ~rst & w_raw & ~w_flush;
`endif

  assign pcStall_o  = w_stall;
  assign fdStall_o  = w_stall;
  assign fdFlush_o  = w_flush;
  assign deFlush_o  = w_flush | w_stall;
  assign fwdA_o     = w_fwd_a;
  assign fwdB_o     = w_fwd_b;
  assign stallCnt_o = r_stall_cnt;
  assign flushCnt_o = r_flush_cnt;

  // Flush sequencer plus the two performance counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_RUN;
      r_cnt       <= 3'd0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (ex_branchTaken_i) begin
            // A single-cycle flush is fully covered by the combinational first cycle.
            if (FLUSH_CYCLES > 1) begin
              r_state <= ST_FLUSH;
              r_cnt   <= LP_CNT_INIT;
            end
          end
        end
        ST_FLUSH: begin
          if (r_cnt <= 3'd1) begin
            r_state <= ST_RUN;
            r_cnt   <= 3'd0;
          end else begin
            r_cnt <= r_cnt - 3'd1;
          end
        end
        default: begin
          r_state <= ST_RUN;
          r_cnt   <= 3'd0;
        end
      endcase

      if (w_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
        r_stall_cnt <= r_stall_cnt + LP_CNT_ONE;
      end
      if (w_branch_accept && (r_flush_cnt != {CNT_W{1'b1}})) begin
        r_flush_cnt <= r_flush_cnt + LP_CNT_ONE;
      end
    end
  end

endmodule
